mem_ctrl: RTL and testbench

Memory controller between the instruction cache, the load/store buffer and the single byte-wide RAM/IO port. It arbitrates word-fetch requests from the instruction cache against load/store requests. Each granted request is sequenced as a 1/2/4-byte burst on the 8-bit RAM port. Write bytes to the IO range are throttled by `io_buffer_full`.

---
 rtl/mem_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates I-cache word fetches against load/store requests and
// sequences each grant as a 1/2/4-byte burst on the byte-wide RAM/IO port.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ic_ena,
  input  logic [31:0] ic_addr,
  output logic        ic_valid,
  output logic [31:0] ic_data,
  input  logic        ls_ena,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_LS = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] result_q, result_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [BW-1:0] mem_dout_q, mem_dout_d;
  logic          mem_wr_q, mem_wr_d;
  logic          ic_valid_q, ic_valid_d;
  logic          ls_valid_q, ls_valid_d;

  logic          grant_ls, grant_ic;
  logic [AW-1:0] grant_addr;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] ls_n;
  logic [1:0]    cap_idx;

  // Round-robin grant: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_ls   = ls_ena && (!ic_ena || (last_q == OWN_IC));
    grant_ic   = ic_ena && !grant_ls;
    grant_addr = grant_ls ? ls_addr : ic_addr;
    case (ls_size)
      2'b00:   ls_n = CW'(1);
      2'b01:   ls_n = CW'(2);
      default: ls_n = CW'(4);
    endcase
    wr_addr = base_q + AW'(cnt_q);
    cap_idx = 2'(cnt_q - CW'(2));
  end

  // In RD, cnt_q is the edge index since grant; in WR, it counts bytes launched.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    base_d     = base_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    result_d   = result_q;
    mem_a_d    = '0;
    mem_dout_d = '0;
    mem_wr_d   = 1'b0;
    ic_valid_d = 1'b0;
    ls_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_ic || grant_ls) begin
          base_d   = grant_addr;
          n_d      = grant_ls ? ls_n : CW'(4);
          wdata_d  = ls_wdata;
          owner_d  = grant_ls ? OWN_LS : OWN_IC;
          last_d   = grant_ls ? OWN_LS : OWN_IC;
          result_d = '0;
          cnt_d    = CW'(1);
          if (grant_ls && ls_wr) begin
            state_d = WR;
            if ((grant_addr >= IO_BASE) && io_buffer_full) begin
              cnt_d = '0;
            end else begin
              mem_wr_d   = 1'b1;
              mem_a_d    = grant_addr;
              mem_dout_d = ls_wdata[BW-1:0];
            end
          end else begin
            state_d = RD;
            mem_a_d = grant_addr;
          end
        end
      end

      RD: begin
        if (cnt_q < n_q) begin
          mem_a_d = base_q + AW'(cnt_q);
        end
        if (cnt_q >= CW'(2)) begin
          result_d[{cap_idx, 3'b000} +: BW] = mem_din;
        end
        if (cnt_q == (n_q + CW'(1))) begin
          ic_valid_d = (owner_q == OWN_IC);
          ls_valid_d = (owner_q == OWN_LS);
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WR: begin
        if (cnt_q == n_q) begin
          ls_valid_d = 1'b1;
          state_d    = IDLE;
        end else if (!((wr_addr >= IO_BASE) && io_buffer_full)) begin
          mem_wr_d   = 1'b1;
          mem_a_d    = wr_addr;
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: BW];
          cnt_d      = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IC;
      last_q     <= OWN_IC;
      base_q     <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      result_q   <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      ic_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      base_q     <= base_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      result_q   <= result_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ic_valid_q <= ic_valid_d;
      ls_valid_q <= ls_valid_d;
    end
  end

  assign ic_valid = ic_valid_q;
  assign ls_valid = ls_valid_q;
  assign ic_data  = result_q;
  assign ls_rdata = result_q;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl driving a byte-wide RAM model.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        ic_ena;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [31:0] ic_data;
  logic        ls_ena;
  logic        ls_wr;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_valid;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  always #5 clk = ~clk;

  mem_ctrl #(.IO_BASE(32'h30000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_ena(ic_ena), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_data(ic_data),
    .ls_ena(ls_ena), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  typedef struct packed {
    logic        is_ls;
    logic        chk;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  resp_t r_pop;
  wr_t   w_pop;

  int n_vec = 0;
  int n_err = 0;
  logic tb_last = 1'b0;

  logic [7:0] ram [0:65535];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // RAM model: output snapshots from the falling edge, rdy-gated like the DUT.
  logic [31:0] a_s  = '0;
  logic [7:0]  d_s  = '0;
  logic        wr_s = 1'b0;
  logic        wr_ev = 1'b0;
  logic [31:0] ev_a = '0;
  logic [7:0]  ev_d = '0;

  always @(posedge clk) begin
    wr_ev <= rdy && wr_s;
    ev_a  <= a_s;
    ev_d  <= d_s;
    if (rdy) begin
      mem_din <= ram[a_s[15:0]];
      if (wr_s) ram[a_s[15:0]] <= d_s;
    end
  end

  always @(negedge clk) begin
    if (wr_ev === 1'b1) begin
      if (wr_q.size() == 0) begin
        check_eq("spurious_write", 32'(wr_ev), 32'd0);
      end else begin
        w_pop = wr_q.pop_front();
        check_eq("wr_addr", ev_a, w_pop.a);
        check_eq("wr_byte", 32'(ev_d), 32'(w_pop.d));
      end
    end
    if (ic_valid === 1'b1 || ls_valid === 1'b1) begin
      if (resp_q.size() == 0) begin
        check_eq("spurious_valid", {30'd0, ic_valid, ls_valid}, 32'd0);
      end else begin
        r_pop = resp_q.pop_front();
        check_eq("owner", {30'd0, ic_valid, ls_valid}, r_pop.is_ls ? 32'd1 : 32'd2);
        if (r_pop.chk) check_eq("rdata", r_pop.is_ls ? ls_rdata : ic_data, r_pop.data);
      end
    end
    a_s  <= mem_a;
    d_s  <= mem_dout;
    wr_s <= mem_wr;
  end

  task automatic push_rd(input logic is_ls, input logic [31:0] data);
    resp_q.push_back('{is_ls: is_ls, chk: 1'b1, data: data});
  endtask

  task automatic push_st(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int k = 0; k < n; k++) begin
      wr_q.push_back('{a: a + 32'(k), d: d[8*k +: 8]});
    end
    resp_q.push_back('{is_ls: 1'b1, chk: 1'b0, data: 32'd0});
  endtask

  task automatic ic_req(input logic [31:0] a);
    ic_addr = a;
    ic_ena  = 1'b1;
    tb_last = 1'b0;
  endtask

  task automatic ls_req(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] d);
    ls_wr    = wr;
    ls_addr  = a;
    ls_size  = sz;
    ls_wdata = d;
    ls_ena   = 1'b1;
    tb_last  = 1'b1;
  endtask

  // Hold requests until their valid pulse, with a cycle budget.
  task automatic run_reqs();
    int cyc;
    cyc = 0;
    while ((ic_ena || ls_ena) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ic_valid) ic_ena = 1'b0;
      if (ls_valid) ls_ena = 1'b0;
    end
    if (ic_ena || ls_ena) begin
      check_eq("req_timeout", {30'd0, ic_ena, ls_ena}, 32'd0);
      ic_ena = 1'b0;
      ls_ena = 1'b0;
    end
  endtask

  // Simultaneous IC word read and LS load; the bench predicts grant order.
  task automatic dual(input logic [31:0] ia, input logic [31:0] iexp,
                      input logic [31:0] la, input logic [1:0] lsz, input logic [31:0] lexp);
    logic ls_first;
    ls_first = (tb_last == 1'b0);
    if (ls_first) begin
      push_rd(1'b1, lexp);
      push_rd(1'b0, iexp);
    end else begin
      push_rd(1'b0, iexp);
      push_rd(1'b1, lexp);
    end
    ic_addr  = ia;
    ls_wr    = 1'b0;
    ls_addr  = la;
    ls_size  = lsz;
    ls_wdata = '0;
    ic_ena   = 1'b1;
    ls_ena   = 1'b1;
    tb_last  = ls_first ? 1'b0 : 1'b1;
    run_reqs();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ic_valid"}, 32'(ic_valid), 32'd0);
    check_eq({tag, "_ls_valid"}, 32'(ls_valid), 32'd0);
    check_eq({tag, "_mem_wr"},   32'(mem_wr),   32'd0);
    check_eq({tag, "_mem_a"},    mem_a,         32'd0);
    check_eq({tag, "_mem_dout"}, 32'(mem_dout), 32'd0);
    check_eq({tag, "_ic_data"},  ic_data,       32'd0);
    check_eq({tag, "_ls_rdata"}, ls_rdata,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
    ram[16'h0104] = 8'hB7; ram[16'h0105] = 8'h12; ram[16'h0106] = 8'h00; ram[16'h0107] = 8'h00;
    ram[16'h0200] = 8'h93; ram[16'h0201] = 8'h00; ram[16'h0202] = 8'h10; ram[16'h0203] = 8'h00;
    ram[16'h0300] = 8'hAA; ram[16'h0301] = 8'hBB; ram[16'h0302] = 8'hCC; ram[16'h0303] = 8'hDD;
    ram[16'h2002] = 8'h34; ram[16'h2003] = 8'h12;

    rst = 1'b0; rdy = 1'b1; ic_ena = 1'b0; ic_addr = '0;
    ls_ena = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_size = '0; ls_wdata = '0;
    io_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // IC word read at 0x100
    @(negedge clk);
    ic_req(32'h100);
    push_rd(1'b0, 32'h00000513);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("rd_addr", mem_a, 32'h100 + 32'(k));
    end
    @(negedge clk);
    check_eq("rd_tail_addr", mem_a, 32'd0);
    check_eq("rd_tail_valid", 32'(ic_valid), 32'd0);
    @(negedge clk);
    check_eq("rd_valid", 32'(ic_valid), 32'd1);
    ic_ena = 1'b0;
    @(negedge clk);
    check_eq("rd_idle_addr", mem_a, 32'd0);
    check_eq("rd_pulse_len", 32'(ic_valid), 32'd0);

    // IO byte store throttled by io_buffer_full for three launch edges
    ls_req(1'b1, 32'h30000, 2'b00, 32'h0000007A);
    io_buffer_full = 1'b1;
    push_st(32'h30000, 1, 32'h0000007A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("io_stall_wr", 32'(mem_wr), 32'd0);
      check_eq("io_stall_addr", mem_a, 32'd0);
    end
    io_buffer_full = 1'b0;
    run_reqs();

    // Arbitration after a fresh reset: LS wins first tie
    @(negedge clk);
    rst = 1'b0;
    tb_last = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    dual(32'h200, 32'h00100093, 32'h2002, 2'b01, 32'h00001234);
    ls_req(1'b0, 32'h2002, 2'b01, 32'd0);
    push_rd(1'b1, 32'h00001234);
    run_reqs();
    dual(32'h104, 32'h000012B7, 32'h2003, 2'b00, 32'h00000012);

    // Word store wrapping past 0xFFFFFFFF, then read it back
    ls_req(1'b1, 32'hFFFFFFFE, 2'b10, 32'hDEADBEEF);
    push_st(32'hFFFFFFFE, 4, 32'hDEADBEEF);
    run_reqs();
    ls_req(1'b0, 32'hFFFFFFFE, 2'b10, 32'd0);
    push_rd(1'b1, 32'hDEADBEEF);
    run_reqs();

    // Reset during byte 2 of an IC read: transaction dropped, no valid
    ic_req(32'h300);
    repeat (3) @(negedge clk);
    check_eq("abort_addr", mem_a, 32'h302);
    rst = 1'b0;
    ic_ena = 1'b0;
    @(negedge clk);
    check_zero("abort");
    tb_last = 1'b0;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    ic_req(32'h100);
    push_rd(1'b0, 32'h00000513);
    run_reqs();

    // rdy low for two cycles in the middle of a word store
    ls_req(1'b1, 32'h400, 2'b10, 32'h11223344);
    push_st(32'h400, 4, 32'h11223344);
    cyc = 0;
    while (ls_ena && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) rdy = 1'b0;
      if (cyc == 4) rdy = 1'b1;
      if (ls_valid) ls_ena = 1'b0;
    end
    rdy = 1'b1;
    ls_ena = 1'b0;
    check_eq("stall_latency", 32'(cyc), 32'd7);
    ls_req(1'b0, 32'h400, 2'b10, 32'd0);
    push_rd(1'b1, 32'h11223344);
    run_reqs();

    repeat (4) @(negedge clk);
    check_eq("resp_q_drained", 32'(resp_q.size()), 32'd0);
    check_eq("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
